// File: rtl/keyexp_if.sv
// Request/response bundle between a key-expansion client and keyexp.
interface keyexp_if;
  logic [127:0]  KEY_i;
  logic          KEY_VALID_i;
  logic          DEC_i;
  logic [1023:0] RK_o;
  logic          RK_READY_o;
  logic          BUSY_o;

  modport master (output KEY_i, KEY_VALID_i, DEC_i,
                  input  RK_o, RK_READY_o, BUSY_o);
  modport slave  (input  KEY_i, KEY_VALID_i, DEC_i,
                  output RK_o, RK_READY_o, BUSY_o);
endinterface

// File: rtl/keyexp.sv
// Iterative SM4 key schedule: one round per two clocks through a registered S-box.
// Define KEYEXP_DEC_EN to build the decryption (reversed) round-key ordering.
module sbox_32b (
  input  logic        CLK_i,
  input  logic [31:0] din,
  output logic [31:0] dout_p1
);
  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  always_ff @(posedge CLK_i)
    dout_p1 <= {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};
endmodule

module keyexp (
  input  logic     CLK_i,
  input  logic     RST_N_i,
  keyexp_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RA, RB, DONE} state_t;

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  state_t      state_q, state_d;
  logic [31:0] k_q [4];
  logic [31:0] rk_q [32];
  logic [4:0]  r_q;
  logic [4:0]  slot;
  logic [31:0] sbox_in_p0, sbox_out_p1, k_new;
  logic        accept;

  function automatic logic [31:0] ck(input logic [4:0] i);
    logic [31:0] c;
    logic [7:0]  idx;
    c = '0;
    for (int j = 0; j < 4; j++) begin
      idx = {1'b0, i, 2'(j)};
      c[31-8*j -: 8] = idx * 8'd7;
    end
    return c;
  endfunction

  function automatic logic [31:0] l_prime(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  assign accept     = ((state_q == IDLE) || (state_q == DONE)) && bus.KEY_VALID_i;
  assign sbox_in_p0 = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck(r_q);
  assign k_new      = k_q[0] ^ l_prime(sbox_out_p1);

  // ---- stage p0 -> p1: S-box registered during RA, consumed in RB ----
  sbox_32b u_sbox (
    .CLK_i   (CLK_i),
    .din     (sbox_in_p0),
    .dout_p1 (sbox_out_p1)
  );

`ifdef KEYEXP_DEC_EN
  logic dec_q;

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i)    dec_q <= 1'b0;
    else if (accept) dec_q <= bus.DEC_i;
  end

  // Reversed order places rk(r) in slot 31-r, which is ~r for a 5-bit index.
  assign slot = dec_q ? ~r_q : r_q;
`else
  assign slot = r_q;
`endif

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.KEY_VALID_i) state_d = RA;
      RA:         state_d = RB;
      RB:         state_d = (r_q == 5'd31) ? DONE : RA;
      default:    state_d = IDLE;
    endcase
  end

  // ---- stage p1 -> window: shift K, store the new round key ----
  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      for (int i = 0; i < 4; i++)  k_q[i]  <= '0;
      for (int i = 0; i < 32; i++) rk_q[i] <= '0;
      r_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < 4; i++)
        k_q[i] <= bus.KEY_i[127-32*i -: 32] ^ FK[127-32*i -: 32];
      r_q <= '0;
    end else if (state_q == RB) begin
      k_q[0]     <= k_q[1];
      k_q[1]     <= k_q[2];
      k_q[2]     <= k_q[3];
      k_q[3]     <= k_new;
      rk_q[slot] <= k_new;
      r_q        <= r_q + 5'd1;
    end
  end

  for (genvar j = 0; j < 32; j++) begin : g_rk
    assign bus.RK_o[32*(32-j)-1 -: 32] = rk_q[j];
  end

  assign bus.RK_READY_o = (state_q == DONE);
  assign bus.BUSY_o     = (state_q == RA) || (state_q == RB);
endmodule

// File: tb/tb_keyexp.sv
// Bench for keyexp: SM4 key-schedule model plus directed timing/abort/restart scenarios.
module tb_keyexp;
  logic CLK_i   = 1'b0;
  logic RST_N_i = 1'b0;
  keyexp_if bus ();

  keyexp dut (
    .CLK_i   (CLK_i),
    .RST_N_i (RST_N_i),
    .bus     (bus)
  );

  always #5 CLK_i = ~CLK_i;

`ifdef KEYEXP_DEC_EN
  localparam bit DEC_EFF = 1'b1;
`else
  localparam bit DEC_EFF = 1'b0;
`endif

  localparam logic [127:0] KEY_A = 128'h0123456789ABCDEFFEDCBA9876543210;

  localparam logic [0:255][7:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SB[a[31:24]], SB[a[23:16]], SB[a[15:8]], SB[a[7:0]]};
  endfunction

  // Whole schedule in one go, then laid out in the requested round order.
  function automatic logic [1023:0] expand(input logic [127:0] mk, input logic dec);
    logic [31:0]   k [36];
    logic [31:0]   fk [4];
    logic [31:0]   ckw, t;
    logic [1023:0] res;
    fk = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
    for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ckw[31-8*j -: 8] = 8'(((4*i+j)*7) % 256);
      t = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ckw);
      k[i+4] = k[i] ^ t ^ ((t << 13) | (t >> 19)) ^ ((t << 23) | (t >> 9));
    end
    for (int j = 0; j < 32; j++)
      res[1023-32*j -: 32] = dec ? k[35-j] : k[j+4];
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    int bad;
    checks++;
    if (act !== exp) begin
      errors++;
      bad = 0;
      for (int j = 31; j >= 0; j--)
        if (act[1023-32*j -: 32] !== exp[1023-32*j -: 32]) bad = j;
      $display("FAIL %s: round %0d got %h expected %h (t=%0t)", name, bad,
               act[1023-32*bad -: 32], exp[1023-32*bad -: 32], $time);
    end
  endtask

  // Transaction-level model: accept when not busy, finish 64 edges later.
  logic          m_busy  = 1'b0;
  logic          m_ready = 1'b0;
  logic [1023:0] m_rk    = '0;
  logic [1023:0] m_next  = '0;
  int            m_cnt   = 0;

  always @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      m_busy <= 1'b0; m_ready <= 1'b0; m_rk <= '0; m_cnt <= 0;
    end else if (!m_busy && bus.KEY_VALID_i) begin
      m_busy  <= 1'b1;
      m_ready <= 1'b0;
      m_cnt   <= 0;
      m_next  <= expand(bus.KEY_i, DEC_EFF & bus.DEC_i);
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 63) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
        m_rk    <= m_next;
      end
    end
  end

  always @(negedge CLK_i) begin
    if (chk_en) begin
      check("busy", 32'(bus.BUSY_o), 32'(m_busy));
      check("ready", 32'(bus.RK_READY_o), 32'(m_ready));
      if (!m_busy) check_rk("rk_bus", bus.RK_o, m_rk);
    end
  end

  task automatic request(input logic [127:0] key, input logic dec);
    @(posedge CLK_i); #1;
    bus.KEY_i = key; bus.DEC_i = dec; bus.KEY_VALID_i = 1'b1;
    @(posedge CLK_i); #1;
    bus.KEY_VALID_i = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.RK_READY_o && n < 200) begin
      @(posedge CLK_i); #1;
      n++;
    end
  endtask

  task automatic check_ends(input string name, input logic [31:0] first, input logic [31:0] last);
    check({name, "_rk_first"}, bus.RK_o[1023:992], first);
    check({name, "_rk_last"},  bus.RK_o[31:0], last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] ex;
    int n;
    bus.KEY_i = '0; bus.DEC_i = 1'b0; bus.KEY_VALID_i = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK_i);
    #1;
    check("rst_busy", 32'(bus.BUSY_o), 32'd0);
    check("rst_ready", 32'(bus.RK_READY_o), 32'd0);
    check("rst_rk0", bus.RK_o[1023:992], 32'd0);
    RST_N_i = 1'b1;
    chk_en  = 1'b1;

    // Pin the model to the published test vector
    ex = expand(KEY_A, 1'b0);
    check("model_enc_rk0", ex[1023:992], 32'hF12186F9);
    check("model_enc_rk31", ex[31:0], 32'h9124A012);
    ex = expand(KEY_A, 1'b1);
    check("model_dec_rk0", ex[1023:992], 32'h9124A012);
    check("model_dec_rk31", ex[31:0], 32'hF12186F9);

    // Encryption order
    request(KEY_A, 1'b0);
    check("enc_busy_after_accept", 32'(bus.BUSY_o), 32'd1);
    wait_ready(n);
    check("enc_latency", n, 64);
    check_ends("enc", 32'hF12186F9, 32'h9124A012);

    // Decryption order (reversed only when built with the feature)
    request(KEY_A, 1'b1);
    wait_ready(n);
    check("dec_latency", n, 64);
    if (DEC_EFF) check_ends("dec", 32'h9124A012, 32'hF12186F9);
    else         check_ends("dec", 32'hF12186F9, 32'h9124A012);

    // Requests and input changes during a running expansion are ignored
    request(KEY_A, 1'b0);
    n = 0;
    while (!bus.RK_READY_o && n < 200) begin
      @(posedge CLK_i); #1;
      n++;
      if (n == 4) begin bus.KEY_i = '0; bus.DEC_i = 1'b1; end
      bus.KEY_VALID_i = (n == 9) || (n == 39);
    end
    bus.KEY_VALID_i = 1'b0;
    check("ignore_latency", n, 64);
    check_ends("ignore", 32'hF12186F9, 32'h9124A012);

    // Asynchronous reset mid-expansion
    request(KEY_A, 1'b0);
    repeat (30) @(posedge CLK_i);
    RST_N_i = 1'b0;
    #1;
    check("abort_busy", 32'(bus.BUSY_o), 32'd0);
    check("abort_ready", 32'(bus.RK_READY_o), 32'd0);
    check("abort_rk0", bus.RK_o[1023:992], 32'd0);
    check("abort_rk31", bus.RK_o[31:0], 32'd0);
    repeat (2) @(posedge CLK_i);
    #1 RST_N_i = 1'b1;
    repeat (5) @(posedge CLK_i);
    #1;
    check("abort_idle_ready", 32'(bus.RK_READY_o), 32'd0);
    request(KEY_A, 1'b0);
    wait_ready(n);
    check("post_abort_latency", n, 64);
    check_ends("post_abort", 32'hF12186F9, 32'h9124A012);

    // Back-to-back from DONE with an all-zero key
    request('0, 1'b0);
    check("b2b_ready_drop", 32'(bus.RK_READY_o), 32'd0);
    wait_ready(n);
    check("b2b_latency", n, 64);
    ex = expand('0, 1'b0);
    check("b2b_rk0", bus.RK_o[1023:992], ex[1023:992]);
    check("b2b_rk31", bus.RK_o[31:0], ex[31:0]);

    // KEY_VALID_i held high in DONE restarts every 65th edge
    @(posedge CLK_i); #1;
    bus.KEY_i = KEY_A; bus.DEC_i = 1'b0; bus.KEY_VALID_i = 1'b1;
    repeat (140) @(posedge CLK_i);
    #1 bus.KEY_VALID_i = 1'b0;
    wait_ready(n);
    check("hold_ready", 32'(bus.RK_READY_o), 32'd1);
    check_ends("hold", 32'hF12186F9, 32'h9124A012);

    repeat (3) @(posedge CLK_i);
    #1 chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
